resp_collect: RTL and testbench

RESP_COLLECT -- requirements
Module: resp_collect

---
 rtl/resp_collect.sv | 115 +++++++++++
 tb/tb_resp_collect.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/resp_collect.sv
// Collects a 450-bit PUF response and a selection vector of the first 128 reliable positions.
// Optional RESP_COLLECT_MASK_EN: unselected b_w positions read as 0 at the output.
module resp_collect (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         bit_valid,
    input  logic         resp_bit,
    input  logic         rel_bit,
    output logic [449:0] b_w,
    output logic [449:0] index_w,
    output logic         load,
    output logic         busy,
    output logic         done,
    output logic         insufficient
);

    // state   | meaning
    // IDLE    | after reset, waiting for start
    // COLLECT | shifting in qualified bits
    // DONE    | vectors final, load pulsed in first cycle, waiting for start
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [8:0] LAST_POS = 9'd449;
    localparam logic [7:0] REL_MAX  = 8'd128;

    state_t       state_q, state_d;
    logic [449:0] b_q, b_d;
    logic [449:0] idx_q, idx_d;
    logic [8:0]   pos_q, pos_d;
    logic [7:0]   rel_q, rel_d;
    logic         load_q, load_d;
    logic         insuf_q, insuf_d;
    logic         take_rel;

    assign take_rel = rel_bit && (rel_q < REL_MAX);

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        rel_d   = rel_q;
        load_d  = 1'b0;
        insuf_d = insuf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = COLLECT;
                    b_d     = '0;
                    idx_d   = '0;
                    pos_d   = '0;
                    rel_d   = '0;
                    insuf_d = 1'b0;
                end
            end
            COLLECT: begin
                if (bit_valid) begin
                    b_d   = {b_q[448:0], resp_bit};
                    idx_d = {idx_q[448:0], take_rel};
                    pos_d = pos_q + 9'd1;
                    if (take_rel) begin
                        rel_d = rel_q + 8'd1;
                    end
                    // 450th accepted bit closes the collection on this same edge
                    if (pos_q == LAST_POS) begin
                        state_d = DONE;
                        load_d  = 1'b1;
                        insuf_d = (rel_d < REL_MAX);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            b_q     <= '0;
            idx_q   <= '0;
            pos_q   <= '0;
            rel_q   <= '0;
            load_q  <= 1'b0;
            insuf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            rel_q   <= rel_d;
            load_q  <= load_d;
            insuf_q <= insuf_d;
        end
    end

    assign index_w      = idx_q;
    assign load         = load_q;
    assign busy         = (state_q == COLLECT);
    assign done         = (state_q == DONE);
    assign insufficient = insuf_q;

`ifdef RESP_COLLECT_MASK_EN
    assign b_w = b_q & idx_q;
`else
    assign b_w = b_q;
`endif

endmodule

// File: tb/tb_resp_collect.sv
// Bench for resp_collect: scenario table with randomized gaps checked against a list-based model.
module tb_resp_collect;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic         bit_valid = 1'b0;
    logic         resp_bit = 1'b0;
    logic         rel_bit = 1'b0;
    logic [449:0] b_w;
    logic [449:0] index_w;
    logic         load;
    logic         busy;
    logic         done;
    logic         insufficient;

    int checks = 0;
    int errors = 0;

    resp_collect dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .bit_valid    (bit_valid),
        .resp_bit     (resp_bit),
        .rel_bit      (rel_bit),
        .b_w          (b_w),
        .index_w      (index_w),
        .load         (load),
        .busy         (busy),
        .done         (done),
        .insufficient (insufficient)
    );

    always #5 clk = ~clk;

    // Model: ordered list of accepted bits of the current collection.
    bit m_resp [450];
    bit m_rel  [450];
    int m_n = 0;

    function automatic void build(output logic [449:0] eb, output logic [449:0] ei);
        int rc = 0;
        eb = '0;
        ei = '0;
        for (int j = 0; j < m_n; j++) begin
            eb[m_n-1-j] = m_resp[j];
            if (m_rel[j]) begin
                if (rc < 128) ei[m_n-1-j] = 1'b1;
                rc++;
            end
        end
`ifdef RESP_COLLECT_MASK_EN
        eb = eb & ei;
`endif
    endfunction

    function automatic int rel_total();
        int t = 0;
        for (int j = 0; j < m_n; j++) t += int'(m_rel[j]);
        return t;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [449:0] act, input logic [449:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic st, input logic bv, input logic rb, input logic lb);
        @(negedge clk);
        start = st; bit_valid = bv; resp_bit = rb; rel_bit = lb;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chkv({tag, "_b"}, b_w, '0);
        chkv({tag, "_idx"}, index_w, '0);
        chk1({tag, "_load"}, load, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_insuf"}, insufficient, 1'b0);
    endtask

    typedef struct {
        int resp_mode;   // 0 alternating 1,0  1 all ones  2 random
        int rel_mode;    // 0 all  1 every 3rd  2 first rel_n  3 random
        int rel_n;
        int gap_pct;
        int exp_pop;     // -1: model only
        int exp_insuf;   // -1: model only
        int exp_last;    // lowest set index_w position, -1: model only
    } vec_t;

    vec_t vecs [7];

    function automatic logic gen_resp(input int mode, input int j);
        case (mode)
            0: return (j % 2 == 0);
            1: return 1'b1;
            default: return logic'($urandom_range(0, 1));
        endcase
    endfunction

    function automatic logic gen_rel(input int mode, input int n, input int j);
        case (mode)
            0: return 1'b1;
            1: return (j % 3 == 0);
            2: return (j < n);
            default: return logic'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_vec(input int k, input vec_t v);
        logic [449:0] eb, ei, hold_b, hold_i;
        int cyc = 0;
        int low;
        logic rb, lb;
        // start cycle carries a valid bit that must be dropped
        step(1'b1, 1'b1, logic'($urandom_range(0, 1)), 1'b1);
        m_n = 0;
        chk1("start_busy", busy, 1'b1);
        chk1("start_done", done, 1'b0);
        chk1("start_insuf", insufficient, 1'b0);
        chkv("start_b", b_w, '0);
        chkv("start_idx", index_w, '0);
        while (m_n < 450 && cyc < 5000) begin
            cyc++;
            if ($urandom_range(0, 99) < v.gap_pct) begin
                step(logic'($urandom_range(0, 1)), 1'b0, logic'($urandom_range(0, 1)),
                     logic'($urandom_range(0, 1)));
            end else begin
                rb = gen_resp(v.resp_mode, m_n);
                lb = gen_rel(v.rel_mode, v.rel_n, m_n);
                step(logic'($urandom_range(0, 1)), 1'b1, rb, lb);
                m_resp[m_n] = rb;
                m_rel[m_n]  = lb;
                m_n++;
            end
            if (m_n < 450) begin
                chk1("collect_load", load, 1'b0);
                chk1("collect_busy", busy, 1'b1);
            end
        end
        chki("collect_budget", m_n, 450);
        build(eb, ei);
        chk1("final_load", load, 1'b1);
        chk1("final_done", done, 1'b1);
        chk1("final_busy", busy, 1'b0);
        chk1("final_insuf_model", insufficient, rel_total() < 128);
        chkv("final_b", b_w, eb);
        chkv("final_idx", index_w, ei);
        if (v.exp_pop >= 0) chki("table_pop", $countones(index_w), v.exp_pop);
        if (v.exp_insuf >= 0) chk1("table_insuf", insufficient, v.exp_insuf[0]);
        if (v.exp_last >= 0) begin
            low = -1;
            for (int i = 449; i >= 0; i--) if (index_w[i]) low = i;
            chki("table_last_pos", low, v.exp_last);
        end
        if (v.resp_mode == 1 && v.exp_pop == 128) begin
`ifdef RESP_COLLECT_MASK_EN
            chkv("mask_b_eq_idx", b_w, index_w);
`else
            chkv("unmasked_all_ones", b_w, {450{1'b1}});
`endif
        end
        hold_b = b_w;
        hold_i = index_w;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), 1'b1);
            chk1("hold_load", load, 1'b0);
            chk1("hold_done", done, 1'b1);
            chkv("hold_b", b_w, hold_b);
            chkv("hold_idx", index_w, hold_i);
        end
        if (k < 0) $display("unused");
    endtask

    initial begin
        vecs[0] = '{0, 0, 0,   0, 128, 0, 322};
        vecs[1] = '{2, 1, 0,  30, 128, 0,  68};
        vecs[2] = '{2, 2, 100, 10, 100, 1, 350};
        vecs[3] = '{1, 2, 128,  0, 128, 0, 322};
        vecs[4] = '{2, 2, 127, 20, 127, 1, 323};
        vecs[5] = '{2, 2, 0,    0,   0, 1,  -1};
        vecs[6] = '{2, 3, 0,   25,  -1, -1, -1};

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("in_reset");
        @(negedge clk);
        resetn = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk_all_zero("idle_valid_ignored");

        // partial run cut short by reset
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk1("pre_rst_busy", busy, 1'b1);
        m_n = 0;
        while (m_n < 200) begin
            if ($urandom_range(0, 3) == 0) step(1'b1, 1'b0, 1'b0, 1'b0);
            else begin
                step(1'b0, 1'b1, logic'($urandom_range(0, 1)), 1'b1);
                m_n++;
            end
            chk1("pre_rst_busy_hold", busy, 1'b1);
        end
        chk1("pre_rst_idx_bit", index_w[127], 1'b1);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1);
            chk_all_zero("post_reset_idle");
        end

        for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
